// File: rtl/tt_arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
package tt_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot2(input logic [1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/tt_rr_pick.sv
// Combinational winner select: rotate requests so the search start sits at bit 0,
// take the lowest set bit, then rotate the index back.
module tt_rr_pick
  import tt_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_ptr,
  input  logic       pri_mode,
  output logic       valid,
  output logic [1:0] win_id
);

  logic [1:0] start;
  logic [7:0] dbl;
  logic [3:0] rot;
  logic [1:0] enc;

  always_comb begin
    start = pri_mode ? 2'd0 : last_ptr + 2'd1;
    dbl   = {req, req} >> start;
    rot   = dbl[3:0];
    enc   = 2'd0;
    // Scan from the top down so the lowest set bit is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = 2'(i);
    end
    valid  = |req;
    win_id = enc + start;
  end

endmodule

// File: rtl/tt_rr_arbiter4.sv
// TinyTapeout wrapper: IDLE/GRANT/GAP arbiter with bounded tenure, lock and a
// one-cycle break-before-make gap. All outputs are registered.
module tt_rr_arbiter4
  import tt_arb_pkg::*;
#(
  parameter  int MAX_HOLD = 8,
  localparam int CNT_W    = $clog2(MAX_HOLD)
) (
  input  logic [7:0] io_in,
  output logic [7:0] io_out
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       lock;
  logic       pri_mode;

  assign clk      = io_in[0];
  assign rst_n    = io_in[1];
  assign req      = io_in[5:2];
  assign lock     = io_in[6];
  assign pri_mode = io_in[7];

  state_t           state, state_nxt;
  logic [3:0]       grant, grant_nxt;
  logic [1:0]       grant_id, id_nxt;
  logic             busy, busy_nxt;
  logic             timeout, timeout_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt;
  logic [1:0]       last_ptr, ptr_nxt;

  logic       pick_valid;
  logic [1:0] win_id;

  tt_rr_pick u_pick (
    .req      (req),
    .last_ptr (last_ptr),
    .pri_mode (pri_mode),
    .valid    (pick_valid),
    .win_id   (win_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      grant_id <= 2'd0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last_ptr <= 2'd3;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      grant_id <= id_nxt;
      busy     <= busy_nxt;
      timeout  <= timeout_nxt;
      hold_cnt <= cnt_nxt;
      last_ptr <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    grant_nxt   = grant;
    id_nxt      = grant_id;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    cnt_nxt     = hold_cnt;
    ptr_nxt     = last_ptr;
    case (state)
      IDLE, GAP: begin
        if (pick_valid) begin
          state_nxt = GRANT;
          grant_nxt = onehot2(win_id);
          id_nxt    = win_id;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
          grant_nxt = 4'b0000;
          busy_nxt  = 1'b0;
        end
      end
      GRANT: begin
        // Release wins over preemption when both happen on the same edge.
        if (!req[grant_id]) begin
          state_nxt = GAP;
          grant_nxt = 4'b0000;
          busy_nxt  = 1'b0;
          ptr_nxt   = grant_id;
        end else if (hold_cnt == HOLD_LAST && !lock &&
                     |(req & ~onehot2(grant_id))) begin
          state_nxt   = GAP;
          grant_nxt   = 4'b0000;
          busy_nxt    = 1'b0;
          timeout_nxt = 1'b1;
          ptr_nxt     = grant_id;
        end else if (hold_cnt != HOLD_LAST) begin
          cnt_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  assign io_out = {timeout, busy, grant_id, grant};

endmodule

// File: tb/tb_tt_rr_arbiter4.sv
// Scoreboard bench for tt_rr_arbiter4: stimulus queues the expected io_out for
// each edge, a monitor pops and compares just after every rising edge.
module tb_tt_rr_arbiter4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       lock = 1'b0;
  logic       pri = 1'b0;
  logic [7:0] io_in;
  logic [7:0] io_out;

  assign io_in = {pri, lock, req, rst_n, clk};

  tt_rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] v;
    string      tag;
  } exp_t;

  exp_t  q[$];
  int    checks = 0;
  int    errors = 0;
  string tag = "init";
  logic  prev_to = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: io_out actual %b required %b (t b id g)", name, act, exp);
    end
  endtask

  // One edge of stimulus with the io_out expected right after that edge.
  task automatic cyc(input logic [3:0] r, input logic lk, input logic pm,
                     input logic [3:0] g, input logic [1:0] id, input logic b,
                     input logic t);
    exp_t e;
    @(negedge clk);
    req  = r;
    lock = lk;
    pri  = pm;
    e.v   = {t, b, id, g};
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check(name, io_out, 8'h00);
    @(negedge clk);
    req   = 4'b0000;
    lock  = 1'b0;
    pri   = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: compare queued expectations and the grant/timeout invariants.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.tag, io_out, e.v);
        checks++;
        if (io_out[3:0] & (io_out[3:0] - 4'd1)) begin
          errors++;
          $display("FAIL onehot %s: grant actual %b required at most one bit", e.tag, io_out[3:0]);
        end
        checks++;
        if (prev_to && io_out[7]) begin
          errors++;
          $display("FAIL timeout_twice %s: timeout actual 1 required 0", e.tag);
        end
        prev_to = io_out[7];
      end else begin
        prev_to = 1'b0;
      end
    end
  end

  initial begin
    int guard;
    #1 check("reset_state", io_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    tag = "single";
    cyc(4'b0001, 0, 0, 4'b0001, 2'd0, 1, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);

    do_reset("reset_rr");
    tag = "rr_preempt";
    for (int i = 0; i < 8; i++) cyc(4'b0101, 0, 0, 4'b0001, 2'd0, 1, 0);
    cyc(4'b0101, 0, 0, 4'b0000, 2'd0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(4'b0101, 0, 0, 4'b0100, 2'd2, 1, 0);
    cyc(4'b0101, 0, 0, 4'b0000, 2'd2, 0, 1);
    for (int i = 0; i < 8; i++) cyc(4'b0101, 0, 0, 4'b0001, 2'd0, 1, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);

    do_reset("reset_lock");
    tag = "lock";
    for (int i = 0; i < 25; i++) cyc(4'b0101, 1, 0, 4'b0001, 2'd0, 1, 0);
    cyc(4'b0101, 0, 0, 4'b0000, 2'd0, 0, 1);
    cyc(4'b0101, 0, 0, 4'b0100, 2'd2, 1, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd2, 0, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd2, 0, 0);

    tag = "fixed_pri";
    cyc(4'b1110, 0, 1, 4'b0010, 2'd1, 1, 0);
    cyc(4'b1110, 0, 1, 4'b0010, 2'd1, 1, 0);
    cyc(4'b1100, 0, 1, 4'b0000, 2'd1, 0, 0);
    cyc(4'b1100, 0, 1, 4'b0100, 2'd2, 1, 0);
    cyc(4'b1110, 0, 1, 4'b0100, 2'd2, 1, 0);
    cyc(4'b1010, 0, 1, 4'b0000, 2'd2, 0, 0);
    cyc(4'b1010, 0, 1, 4'b0010, 2'd1, 1, 0);
    cyc(4'b1110, 0, 1, 4'b0010, 2'd1, 1, 0);
    cyc(4'b0000, 0, 1, 4'b0000, 2'd1, 0, 0);
    cyc(4'b0000, 0, 1, 4'b0000, 2'd1, 0, 0);

    do_reset("reset_rr2");
    tag = "rr_order";
    cyc(4'b1110, 0, 0, 4'b0010, 2'd1, 1, 0);
    cyc(4'b1110, 0, 0, 4'b0010, 2'd1, 1, 0);
    cyc(4'b1100, 0, 0, 4'b0000, 2'd1, 0, 0);
    cyc(4'b1100, 0, 0, 4'b0100, 2'd2, 1, 0);
    cyc(4'b1110, 0, 0, 4'b0100, 2'd2, 1, 0);
    cyc(4'b1010, 0, 0, 4'b0000, 2'd2, 0, 0);
    cyc(4'b1010, 0, 0, 4'b1000, 2'd3, 1, 0);
    cyc(4'b1110, 0, 0, 4'b1000, 2'd3, 1, 0);
    cyc(4'b0110, 0, 0, 4'b0000, 2'd3, 0, 0);
    cyc(4'b0110, 0, 0, 4'b0010, 2'd1, 1, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd1, 0, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd1, 0, 0);

    do_reset("reset_mid0");
    tag = "mid_reset";
    for (int i = 0; i < 8; i++) cyc(4'b0101, 0, 0, 4'b0001, 2'd0, 1, 0);
    cyc(4'b0101, 0, 0, 4'b0000, 2'd0, 0, 1);
    for (int i = 0; i < 6; i++) cyc(4'b0101, 0, 0, 4'b0100, 2'd2, 1, 0);
    do_reset("async_reset_mid_grant");
    tag = "after_reset";
    cyc(4'b1111, 0, 0, 4'b0001, 2'd0, 1, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd0, 0, 0);

    do_reset("reset_race");
    tag = "release_vs_preempt";
    for (int i = 0; i < 8; i++) cyc(4'b0011, 0, 0, 4'b0001, 2'd0, 1, 0);
    cyc(4'b0010, 0, 0, 4'b0000, 2'd0, 0, 0);
    cyc(4'b0010, 0, 0, 4'b0010, 2'd1, 1, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd1, 0, 0);
    cyc(4'b0000, 0, 0, 4'b0000, 2'd1, 0, 0);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: pending expectations actual %0d required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
